uart_tx: RTL and testbench

//   UART serial transmitter of the BIP board link, directly downstream of the CPU/UART

---
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, SB_TICK-tick stop period.
// Paced by a 16x oversampling s_tick; one-cycle tx_done_tick per completed frame.
`timescale 1ns/1ps
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_done_tick,
  output logic            tx_busy
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_ONE       = SW'(1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_ONE       = NW'(1);

  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            done_d;
  logic            tx_d;

  // Handshake: tx_start is a level request sampled only in IDLE; tx_done_tick is a
  // single-cycle pulse in the first IDLE cycle after STOP, and no start is accepted
  // in that cycle so the requester has one clock to drop tx_start.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start && !tx_done_tick) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            // din is captured here, at the end of the start bit
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
            b_d     = din;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + N_ONE;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d = IDLE;
            s_d     = '0;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level follows the current state, so tx lags the state change by one clock
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_q[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_busy      <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      tx           <= tx_d;
      tx_done_tick <= done_d;
      tx_busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line monitor decodes frames against an expected-byte queue,
// while scenario tasks check done pulses, busy, reset and stall behaviour.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx;
  logic       tx_done_tick;
  logic       tx_busy;

  int         n_tests = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];
  bit         tick_en = 1'b1;
  int         tick_cnt = 0;

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk),
    .reset(reset),
    .s_tick(s_tick),
    .tx_start(tx_start),
    .din(din),
    .tx(tx),
    .tx_done_tick(tx_done_tick),
    .tx_busy(tx_busy)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        tick_cnt = (tick_cnt == 3) ? 0 : tick_cnt + 1;
        s_tick = (tick_cnt == 3);
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) done_cnt++;
  end

  // ---------------- line monitor / scoreboard ----------------
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [9:0] mon_frame = '0;
  logic [3:0] mon_idx;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
        mon_frame = '0;
      end
    end else if (s_tick) begin
      mon_cnt++;
      if (mon_cnt % 16 == 8) begin
        mon_idx = 4'(mon_cnt / 16);
        mon_frame[mon_idx] = tx;
        if (mon_idx == 4'd9) begin
          mon_active = 1'b0;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_frame: got frame %b, expected no frame", mon_frame);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_frame !== {1'b1, mon_exp, 1'b0}) begin
              n_fail++;
              $display("FAIL frame: got %b, expected %b", mon_frame, {1'b1, mon_exp, 1'b0});
            end
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_done_tick === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_ticks(input int n);
    int t;
    t = 0;
    while (t < n) begin
      @(negedge clk);
      if (s_tick) t++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, expected 1", tx); end
    n_tests++;
    if (tx_done_tick !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", tx_done_tick); end
    n_tests++;
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", tx_busy); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int d0;
    bit ok;
    d0 = done_cnt;
    din = 8'hA5;
    tx_start = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    tx_start = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_high: got %b, expected 1", tx_busy); end
    n_tests++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL single_start_bit: got %b, expected 0", tx); end
    wait_done(2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_done_timeout: got no done, expected done"); end
    @(negedge clk);
    n_tests++;
    if (tx_done_tick !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b, expected 0", tx_done_tick); end
    n_tests++;
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_low: got %b, expected 0", tx_busy); end
    repeat (100) @(negedge clk);
    n_tests++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d, expected 1", done_cnt - d0); end
    n_tests++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL single_idle_tx: got %b, expected 1", tx); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_queue: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_late_din;
    int d0;
    bit ok;
    d0 = done_cnt;
    din = 8'h12;
    tx_start = 1'b1;
    exp_q.push_back(8'h34);
    @(negedge clk);
    n_tests++;
    if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL late_busy: got %b, expected 1", tx_busy); end
    wait_ticks(10);
    din = 8'h34;
    tx_start = 1'b0;
    wait_ticks(30);
    din = 8'hFF;
    wait_done(2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL late_done_timeout: got no done, expected done"); end
    repeat (20) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL late_queue: got %0d pending, expected 0", exp_q.size()); end
    n_tests++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL late_done_count: got %0d, expected 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    int d0;
    bit ok;
    d0 = done_cnt;
    din = 8'h11;
    tx_start = 1'b1;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    for (int k = 0; k < 3; k++) begin
      wait_done(2000, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL b2b_done_timeout_%0d: got no done, expected done", k); end
      n_tests++;
      if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_in_done_%0d: got %b, expected 0", k, tx_busy); end
      if (k < 2) begin
        repeat (2) @(negedge clk);
        din = (k == 0) ? 8'h22 : 8'h33;
      end else begin
        @(negedge clk);
        tx_start = 1'b0;
      end
    end
    repeat (400) @(negedge clk);
    n_tests++;
    if (done_cnt - d0 !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d, expected 3", done_cnt - d0); end
    n_tests++;
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_fourth: got busy %b, expected 0", tx_busy); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_queue: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_start_on_done;
    int d0;
    int bad;
    bit ok;
    d0 = done_cnt;
    din = 8'h5A;
    tx_start = 1'b1;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    tx_start = 1'b0;
    wait_done(2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL sod_done_timeout: got no done, expected done"); end
    tx_start = 1'b1;
    din = 8'hE7;
    @(negedge clk);
    tx_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL sod_no_frame: got %0d active cycles, expected 0", bad); end
    n_tests++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL sod_done_count: got %0d, expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    int d0;
    int bad;
    d0 = done_cnt;
    din = 8'hC3;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_ticks(70);
    n_tests++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL rmid_data_bit3: got %b, expected 0", tx); end
    reset = 1'b1;
    #1;
    n_tests++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL rmid_async_tx: got %b, expected 1", tx); end
    n_tests++;
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async_busy: got %b, expected 0", tx_busy); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_done_tick !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL rmid_idle_after: got %0d bad cycles, expected 0", bad); end
    n_tests++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses, expected 0", done_cnt - d0); end
  endtask

  task automatic test_stall;
    int d0;
    int bad;
    logic tx_ref;
    bit ok;
    d0 = done_cnt;
    din = 8'h96;
    tx_start = 1'b1;
    exp_q.push_back(8'h96);
    @(negedge clk);
    tx_start = 1'b0;
    wait_ticks(40);
    tick_en = 1'b0;
    repeat (3) @(negedge clk);
    tx_ref = tx;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== tx_ref || tx_busy !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_frozen: got %0d changed cycles, expected 0", bad); end
    tick_en = 1'b1;
    wait_done(2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL stall_done_timeout: got no done, expected done"); end
    repeat (20) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_queue: got %0d pending, expected 0", exp_q.size()); end
    n_tests++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL stall_done_count: got %0d, expected 1", done_cnt - d0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_late_din();
    test_back_to_back();
    test_start_on_done();
    test_reset_mid();
    test_stall();
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
